// File: rtl/csa_pkg.sv
// Shared types and reference arithmetic for the carry-select adder and its BIST engine.
package csa_pkg;

   localparam int WIDTH = 4;
   localparam int IDX_W = 2*WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Golden {cout,sum}; operand widths follow the package WIDTH.
   function automatic logic [WIDTH:0] csa_ref(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             cin);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/csa_bist_engine_if.sv
// Adder-facing bus of the BIST engine: operands out, response back.
interface csa_bist_engine_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] dut_a;
   logic [WIDTH-1:0] dut_b;
   logic             dut_cin;
   logic [WIDTH-1:0] dut_s;
   logic             dut_cout;

   modport master (output dut_a, dut_b, dut_cin, input  dut_s, dut_cout);
   modport slave  (input  dut_a, dut_b, dut_cin, output dut_s, dut_cout);
endinterface

// File: rtl/csa_bist_delay.sv
// DEPTH-stage {valid,data} shift register that tracks the adder pipeline.
// DEPTH=0 is a plain pass-through.
module csa_bist_delay #(
   parameter int DEPTH = 0,
   parameter int DW    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_ena,
   input  logic          i_flush,
   input  logic          i_vld,
   input  logic [DW-1:0] i_data,
   output logic          o_vld,
   output logic [DW-1:0] o_data
);
   generate
      if (DEPTH == 0) begin : g_bypass
         logic w_unused;
         assign w_unused = clk ^ rst_n ^ i_ena ^ i_flush;
         assign o_vld    = i_vld;
         assign o_data   = i_data;
      end else begin : g_pipe
         logic [DEPTH-1:0] r_vld;
         logic [DW-1:0]    r_data [DEPTH];

         // Flush only kills valid bits; stale data is harmless without them.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= '0;
               for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
            end else if (i_ena) begin
               r_vld[0]  <= i_vld & ~i_flush;
               r_data[0] <= i_data;
               for (int i = 1; i < DEPTH; i++) begin
                  r_vld[i]  <= r_vld[i-1] & ~i_flush;
                  r_data[i] <= r_data[i-1];
               end
            end
         end

         assign o_vld  = r_vld[DEPTH-1];
         assign o_data = r_data[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/csa_bist_engine.sv
// Exhaustive self-test for the carry-select adder: sweeps every {cin,B,A},
// checks each response against csa_ref and keeps error count and first failure.
module csa_bist_engine
   import csa_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int DUT_LAT = 0,
   parameter int ERR_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 start,
   input  logic                 abort,
   csa_bist_engine_if.master    dut_if,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_W-1:0]     err_count,
   output logic                 first_fail_vld,
   output logic [2*WIDTH:0]     first_fail_idx
);
   localparam int VEC_W   = 2*WIDTH + 1;
   localparam int DW      = WIDTH + 1 + VEC_W;
   localparam int DRAIN_W = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
   localparam logic [VEC_W-1:0]   LAST_M1 = VEC_W'((1 << VEC_W) - 2);
   localparam logic [DRAIN_W-1:0] LAT_END = DRAIN_W'(DUT_LAT);

   state_t             r_state;
   logic [VEC_W-1:0]   r_vec;        // {cin,b,a} currently on the adder inputs
   logic               r_iss_vld;
   logic [DRAIN_W-1:0] r_drain;
   logic               r_busy, r_done, r_pass, r_ff_vld;
   logic [ERR_W-1:0]   r_err;
   logic [VEC_W-1:0]   r_ff_idx;

   logic               w_cmp_vld;
   logic [DW-1:0]      w_cmp_data;
   logic [WIDTH:0]     w_cmp_exp;
   logic [VEC_W-1:0]   w_cmp_idx;
   logic               w_mismatch;
   logic [ERR_W-1:0]   w_err_next;

   assign dut_if.dut_a   = r_vec[WIDTH-1:0];
   assign dut_if.dut_b   = r_vec[2*WIDTH-1:WIDTH];
   assign dut_if.dut_cin = r_vec[2*WIDTH];

   // Expected value is formed from the issued operands and then delayed with them.
   csa_bist_delay #(.DEPTH(DUT_LAT), .DW(DW)) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ena   (ena),
      .i_flush (abort),
      .i_vld   (r_iss_vld),
      .i_data  ({csa_ref(dut_if.dut_a, dut_if.dut_b, dut_if.dut_cin), r_vec}),
      .o_vld   (w_cmp_vld),
      .o_data  (w_cmp_data)
   );

   assign w_cmp_exp  = w_cmp_data[DW-1 -: WIDTH+1];
   assign w_cmp_idx  = w_cmp_data[VEC_W-1:0];
   assign w_mismatch = w_cmp_vld && ({dut_if.dut_cout, dut_if.dut_s} != w_cmp_exp);
   assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_vec     <= '0;
         r_iss_vld <= 1'b0;
         r_drain   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_err     <= '0;
         r_ff_vld  <= 1'b0;
         r_ff_idx  <= '0;
      end else if (ena) begin
         r_iss_vld <= 1'b0;
         if (abort) begin
            // Results stay visible for debug; the in-flight compare is dropped.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
         end else begin
            r_err <= w_err_next;
            if (w_mismatch && !r_ff_vld) begin
               r_ff_vld <= 1'b1;
               r_ff_idx <= w_cmp_idx;
            end
            case (r_state)
               IDLE, DONE: begin
                  if (start) begin
                     r_state   <= RUN;
                     r_vec     <= '0;
                     r_iss_vld <= 1'b1;
                     r_err     <= '0;
                     r_ff_vld  <= 1'b0;
                     r_ff_idx  <= '0;
                     r_pass    <= 1'b0;
                     r_done    <= 1'b0;
                     r_busy    <= 1'b1;
                  end
               end
               RUN: begin
                  r_vec     <= r_vec + VEC_W'(1);
                  r_iss_vld <= 1'b1;
                  if (r_vec == LAST_M1) begin
                     r_state <= DRAIN;
                     r_drain <= '0;
                  end
               end
               DRAIN: begin
                  if (r_drain == LAT_END) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= (w_err_next == '0);
                  end else begin
                     r_drain <= r_drain + DRAIN_W'(1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err;
   assign first_fail_vld = r_ff_vld;
   assign first_fail_idx = r_ff_idx;
endmodule

// File: tb/tb_csa_bist_engine.sv
// Bench for csa_bist_engine: a combinational (LAT 0) and a twice-registered (LAT 2)
// adder, each with selectable faults, checked against a sweep-level model.
`timescale 1ns/1ps
module tb_csa_bist_engine;
   import csa_pkg::*;

   localparam int NV = 512;

   logic       clk = 1'b0;
   logic       rst_n, ena;
   logic [1:0] start_v, abort_v;
   logic [1:0] busy_w, done_w, pass_w, ffv_w;
   logic [7:0] err_w [2];
   logic [8:0] ffi_w [2];
   logic [8:0] vec_w [2];
   logic [4:0] p1, p2;
   int         fmode, flo, fhi;
   logic [4:0] fmask;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   // Adder behaviour: 0 good, 1 S[0] stuck at 0, 2 cout inverted, 3 mask on an index range.
   function automatic logic [4:0] adder_out(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin, input int mode, input int lo,
                                            input int hi, input logic [4:0] mask);
      logic [4:0] s;
      int         idx;
      s   = 5'(a) + 5'(b) + 5'(cin);
      idx = int'({cin, b, a});
      case (mode)
         1: s[0] = 1'b0;
         2: s[4] = ~s[4];
         3: if (idx >= lo && idx <= hi) s = s ^ mask;
         default: ;
      endcase
      return s;
   endfunction

   csa_bist_engine_if #(.WIDTH(4)) if0 ();
   csa_bist_engine_if #(.WIDTH(4)) if1 ();

   assign {if0.dut_cout, if0.dut_s} = adder_out(if0.dut_a, if0.dut_b, if0.dut_cin,
                                                fmode, flo, fhi, fmask);
   always @(posedge clk) begin
      if (ena) begin
         p1 <= adder_out(if1.dut_a, if1.dut_b, if1.dut_cin, fmode, flo, fhi, fmask);
         p2 <= p1;
      end
   end
   assign {if1.dut_cout, if1.dut_s} = p2;

   assign vec_w[0] = {if0.dut_cin, if0.dut_b, if0.dut_a};
   assign vec_w[1] = {if1.dut_cin, if1.dut_b, if1.dut_a};

   csa_bist_engine #(.WIDTH(4), .DUT_LAT(0), .ERR_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_v[0]), .abort(abort_v[0]),
      .dut_if(if0), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err_w[0]), .first_fail_vld(ffv_w[0]), .first_fail_idx(ffi_w[0])
   );

   csa_bist_engine #(.WIDTH(4), .DUT_LAT(2), .ERR_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_v[1]), .abort(abort_v[1]),
      .dut_if(if1), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err_w[1]), .first_fail_vld(ffv_w[1]), .first_fail_idx(ffi_w[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Mismatches among vectors 0..limit-1 under the current fault setting.
   task automatic model(input int limit, output int cnt, output int first);
      int         a, b, c;
      logic [4:0] got;
      cnt   = 0;
      first = -1;
      for (int i = 0; i < limit; i++) begin
         a   = i % 16;
         b   = (i / 16) % 16;
         c   = i / 256;
         got = adder_out(4'(a), 4'(b), c[0], fmode, flo, fhi, fmask);
         if (int'(got) != a + b + c) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
   endtask

   task automatic start_pulse(input int sel);
      @(negedge clk);
      start_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      start_v[sel] = 1'b0;
   endtask

   task automatic run_full(input int sel, input int lat, input int stall_at, input string tag);
      int edges, busy_cnt, cnt, first, stall_len;
      bit stalled;
      model(NV, cnt, first);
      stall_len = (stall_at >= 0) ? 10 : 0;
      start_pulse(sel);
      edges    = 0;
      busy_cnt = int'(busy_w[sel]);
      stalled  = 1'b0;
      while (!done_w[sel] && edges < 3000) begin
         if (!stalled && stall_at >= 0 && int'(vec_w[sel]) == stall_at) begin
            stalled = 1'b1;
            ena     = 1'b0;
            repeat (10) begin
               @(posedge clk);
               #1;
               edges++;
               busy_cnt += int'(busy_w[sel]);
            end
            check({tag, " held idx"}, 32'(vec_w[sel]), stall_at);
            ena = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            edges++;
            busy_cnt += int'(busy_w[sel]);
         end
      end
      check({tag, " done"},      32'(done_w[sel]), 1);
      check({tag, " done edge"}, edges, NV + lat + stall_len);
      check({tag, " busy cyc"},  busy_cnt, NV + lat + stall_len);
      check({tag, " pass"},      32'(pass_w[sel]), (cnt == 0) ? 1 : 0);
      check({tag, " err"},       32'(err_w[sel]), (cnt > 255) ? 255 : cnt);
      check({tag, " ff vld"},    32'(ffv_w[sel]), (cnt > 0) ? 1 : 0);
      check({tag, " ff idx"},    32'(ffi_w[sel]), (first < 0) ? 0 : first);
      $display("run %s: dut%0d edges=%0d err=%0d ff_idx=%0d pass=%0d",
               tag, sel, edges, err_w[sel], ffi_w[sel], pass_w[sel]);
   endtask

   task automatic run_until(input int sel, input int target, output bit found);
      found = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         if (int'(vec_w[sel]) == target) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt, first;
      bit  found;
      rst_n   = 1'b0;
      ena     = 1'b1;
      start_v = '0;
      abort_v = '0;
      fmode   = 0;
      flo     = 0;
      fhi     = 0;
      fmask   = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check("reset busy", 32'(busy_w[s]), 0);
         check("reset done", 32'(done_w[s]), 0);
         check("reset pass", 32'(pass_w[s]), 0);
         check("reset err",  32'(err_w[s]), 0);
         check("reset ffv",  32'(ffv_w[s]), 0);
         check("reset vec",  32'(vec_w[s]), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      fmode = 0; run_full(0, 0, -1, "good lat0");
      fmode = 1; run_full(0, 0, -1, "s0 stuck");
      fmode = 0; run_full(1, 2, -1, "good lat2");
      fmode = 2; run_full(1, 2, -1, "cout inv lat2");
      fmode = 0; run_full(0, 0, 100, "ena stall");

      // Abort mid-run on a faulty adder: vectors 0..199 have been compared.
      fmode = 1;
      start_pulse(0);
      run_until(0, 200, found);
      check("abort reach", 32'(found), 1);
      abort_v[0] = 1'b1;
      @(posedge clk);
      #1;
      abort_v[0] = 1'b0;
      model(200, cnt, first);
      check("abort busy", 32'(busy_w[0]), 0);
      check("abort done", 32'(done_w[0]), 0);
      check("abort pass", 32'(pass_w[0]), 0);
      check("abort err",  32'(err_w[0]), cnt);
      check("abort ffi",  32'(ffi_w[0]), first);
      repeat (3) @(posedge clk);
      #1;
      check("abort err hold", 32'(err_w[0]), cnt);
      $display("abort: err=%0d ff_idx=%0d", err_w[0], ffi_w[0]);
      fmode = 0; run_full(0, 0, -1, "post abort");

      // Asynchronous reset mid-run.
      fmode = 1;
      start_pulse(0);
      run_until(0, 300, found);
      check("rst reach", 32'(found), 1);
      rst_n = 1'b0;
      #1;
      check("rst busy", 32'(busy_w[0]), 0);
      check("rst done", 32'(done_w[0]), 0);
      check("rst err",  32'(err_w[0]), 0);
      check("rst ffv",  32'(ffv_w[0]), 0);
      check("rst ffi",  32'(ffi_w[0]), 0);
      check("rst vec",  32'(vec_w[0]), 0);
      $display("reset mid-run: busy=%0d err=%0d vec=%0d", busy_w[0], err_w[0], vec_w[0]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      fmode = 0; run_full(0, 0, -1, "post reset");

      for (int r = 0; r < 4; r++) begin
         fmode = 3;
         flo   = int'($urandom_range(0, 511));
         fhi   = flo + int'($urandom_range(0, 300));
         if (fhi > 511) fhi = 511;
         fmask = 5'($urandom_range(1, 31));
         run_full(r % 2, (r % 2 == 1) ? 2 : 0, -1, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
